// File: rtl/approx_tree_pkg.sv
// rtl/approx_tree_pkg.sv - shared helpers for the pipelined approximate adder tree
package approx_tree_pkg;

  // Working width for node arithmetic; every node result fits well inside it.
  localparam int APX_MAXW = 64;

  // Ceiling log2 used to derive the tree depth from the operand count.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Output width of a node at level lvl (0 = level fed by the operands).
  function automatic int node_w(input int w_in, input int lvl);
    return w_in + lvl + 1;
  endfunction

  // One 2-input node: exact add, or lower-part OR approximation of the k low bits
  // with bit 0 forced high and a carry guessed from bit k-1 of both operands.
  function automatic logic [APX_MAXW-1:0] apx_add(input logic [APX_MAXW-1:0] a,
                                                  input logic [APX_MAXW-1:0] b,
                                                  input int k,
                                                  input logic mode);
    logic [APX_MAXW-1:0] lo_mask;
    logic [APX_MAXW-1:0] lo;
    logic [APX_MAXW-1:0] hi;
    logic [APX_MAXW-1:0] cin_v;
    if (!mode || k == 0) begin
      return a + b;
    end
    lo_mask = (APX_MAXW'(1) << k) - APX_MAXW'(1);
    lo      = ((a | b) & lo_mask) | APX_MAXW'(1);
    cin_v   = ((a & b) >> (k - 1)) & APX_MAXW'(1);
    hi      = (a >> k) + (b >> k) + cin_v;
    return (hi << k) | lo;
  endfunction

endpackage

// File: rtl/apx_tree_level.sv
// rtl/apx_tree_level.sv - one registered adder-tree level; ERR_MON_EN adds an exact shadow path
module apx_tree_level
  import approx_tree_pkg::*;
#(
  parameter int NI = 8,
  parameter int WI = 8,
  parameter int K  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         in_mode,
  input  logic [NI*WI-1:0]             in_data,
  output logic                         out_valid,
  output logic                         out_mode,
  output logic [(NI/2)*(WI+1)-1:0]     out_data
`ifdef ERR_MON_EN
  ,
  input  logic [NI*WI-1:0]             in_shadow,
  output logic [(NI/2)*(WI+1)-1:0]     out_shadow
`endif
);

  localparam int NO = NI / 2;
  localparam int WO = WI + 1;

  logic [NO*WO-1:0] nxt_data;

  // Pairwise node sums in the mode carried by this sample.
  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < NO; i++) begin
      nxt_data[i*WO +: WO] = WO'(apx_add(APX_MAXW'(in_data[2*i*WI +: WI]),
                                         APX_MAXW'(in_data[(2*i+1)*WI +: WI]),
                                         K, in_mode));
    end
  end

  // Stage register; holds everything while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_data  <= nxt_data;
    end
  end

`ifdef ERR_MON_EN
  logic [NO*WO-1:0] nxt_shadow;

  // Exact reference sums for the error monitor.
  always_comb begin
    nxt_shadow = '0;
    for (int i = 0; i < NO; i++) begin
      nxt_shadow[i*WO +: WO] = WO'(apx_add(APX_MAXW'(in_shadow[2*i*WI +: WI]),
                                           APX_MAXW'(in_shadow[(2*i+1)*WI +: WI]),
                                           K, 1'b0));
    end
  end

  // Shadow stage register, advancing in lockstep with the main stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_shadow <= '0;
    end else if (en) begin
      out_shadow <= nxt_shadow;
    end
  end
`endif

endmodule

// File: rtl/approx_adder_tree_pipe.sv
// rtl/approx_adder_tree_pipe.sv - pipelined N-input approximate adder tree, optional ERR_MON_EN error monitor
module approx_adder_tree_pipe
  import approx_tree_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int W_IN  = 8,
  parameter int K_APX = 3,
  localparam int LVLS = clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*W_IN-1:0]   in_data,
  input  logic                   apx_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W_IN+LVLS-1:0]   out_sum,
  output logic                   out_mode
`ifdef ERR_MON_EN
  ,
  output logic [W_IN+LVLS-1:0]   err_abs,
  output logic [W_IN+LVLS-1:0]   err_max
`endif
);

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int NI = N_IN >> l;
    localparam int WI = W_IN + l;
    localparam int WO = node_w(W_IN, l);

    logic [NI*WI-1:0]     din;
    logic                 vin;
    logic                 min;
    logic [(NI/2)*WO-1:0] dout;
    logic                 vout;
    logic                 mout;
`ifdef ERR_MON_EN
    logic [NI*WI-1:0]     sin;
    logic [(NI/2)*WO-1:0] sout;
`endif

    if (l == 0) begin : g_head
      assign din = in_data;
      assign vin = in_valid;
      assign min = apx_mode;
`ifdef ERR_MON_EN
      assign sin = in_data;
`endif
    end else begin : g_link
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
      assign min = g_lvl[l-1].mout;
`ifdef ERR_MON_EN
      assign sin = g_lvl[l-1].sout;
`endif
    end

    apx_tree_level #(
      .NI (NI),
      .WI (WI),
      .K  (K_APX)
    ) u_level (
      .clk        (clk),
      .rst        (rst),
      .en         (adv),
      .in_valid   (vin),
      .in_mode    (min),
      .in_data    (din),
      .out_valid  (vout),
      .out_mode   (mout),
      .out_data   (dout)
`ifdef ERR_MON_EN
      ,
      .in_shadow  (sin),
      .out_shadow (sout)
`endif
    );
  end

  assign out_valid = g_lvl[LVLS-1].vout;
  assign out_mode  = g_lvl[LVLS-1].mout;
  assign out_sum   = g_lvl[LVLS-1].dout;

`ifdef ERR_MON_EN
  logic [W_IN+LVLS-1:0] exact_sum;
  assign exact_sum = g_lvl[LVLS-1].sout;
  assign err_abs   = (out_sum >= exact_sum) ? (out_sum - exact_sum) : (exact_sum - out_sum);

  // Running maximum over samples actually handed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_max <= '0;
    end else if (out_valid && out_ready && (err_abs > err_max)) begin
      err_max <= err_abs;
    end
  end
`endif

endmodule

// File: tb/tb_approx_adder_tree_pipe.sv
// tb/tb_approx_adder_tree_pipe.sv - randomized self-checking bench for approx_adder_tree_pipe
module tb_approx_adder_tree_pipe;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int LV = 3;
  localparam int SW = W + LV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*W-1:0] in_data = '0;
  logic          apx_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sum;
  logic          out_mode;
`ifdef ERR_MON_EN
  logic [SW-1:0] err_abs;
  logic [SW-1:0] err_max;
`endif

  approx_adder_tree_pipe #(.N_IN(N), .W_IN(W), .K_APX(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .apx_mode  (apx_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_mode  (out_mode)
`ifdef ERR_MON_EN
    ,
    .err_abs   (err_abs),
    .err_max   (err_max)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [SW-1:0] exp_sum[$];
  logic          exp_mode[$];
  logic [SW-1:0] exp_err[$];
  longint        model_max = 0;

  logic          did_in, did_out, obs_mode, obs_valid;
  logic [SW-1:0] obs_sum, obs_err;

  // Reference node straight from the arithmetic definition (div/mod by 2^K).
  function automatic longint ref_node(input longint a, input longint b, input logic m);
    longint p, lo, cin, hi;
    if (!m) return a + b;
    p   = longint'(1) << K;
    lo  = ((a | b) % p) | 1;
    cin = ((a / (p / 2)) % 2) * ((b / (p / 2)) % 2);
    hi  = a / p + b / p + cin;
    return hi * p + lo;
  endfunction

  function automatic longint ref_sum(input logic [N*W-1:0] d, input logic m);
    longint v[N];
    int     n;
    for (int i = 0; i < N; i++) v[i] = longint'(d[i*W +: W]);
    n = N;
    while (n > 1) begin
      for (int i = 0; i < n / 2; i++) v[i] = ref_node(v[2*i], v[2*i+1], m);
      n = n / 2;
    end
    return v[0];
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) begin
      d[i*W +: W] = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom());
    end
    return d;
  endfunction

  // One clock of stimulus; records which handshakes happen at the coming edge.
  task automatic step(input logic v, input logic [N*W-1:0] d, input logic m, input logic ordy);
    longint a, e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    apx_mode  = m;
    out_ready = ordy;
    #1;
    did_in    = in_valid && in_ready;
    did_out   = out_valid && out_ready;
    obs_valid = out_valid;
    obs_sum   = out_sum;
    obs_mode  = out_mode;
`ifdef ERR_MON_EN
    obs_err   = err_abs;
`else
    obs_err   = '0;
`endif
    if (did_out && exp_err.size() > 0 && longint'(exp_err[0]) > model_max) model_max = longint'(exp_err[0]);
    if (did_in) begin
      a = ref_sum(d, m);
      e = ref_sum(d, 1'b0);
      exp_sum.push_back(SW'(a));
      exp_mode.push_back(m);
      exp_err.push_back(SW'((a > e) ? a - e : e - a));
    end
  endtask

  task automatic run_one(input logic [N*W-1:0] d, input logic m,
                         output int lat, output logic [SW-1:0] s, output logic md, output logic [SW-1:0] er);
    lat = -1; s = '0; md = 1'b0; er = '0;
    step(1'b1, d, m, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (did_out) begin
        lat = c; s = obs_sum; md = obs_mode; er = obs_err;
        break;
      end
    end
  endtask

  task automatic clear_model();
    exp_sum.delete(); exp_mode.delete(); exp_err.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== '0) begin n_errors++; $display("FAIL reset_sum: got %0d expected 0", out_sum); end
    n_checks++; if (out_mode !== 1'b0) begin n_errors++; $display("FAIL reset_mode: got %b expected 0", out_mode); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    clear_model();
  endtask

  task automatic test_corners();
    logic [N*W-1:0] vec [4];
    logic           md  [4];
    logic [SW-1:0]  want[4];
    logic [SW-1:0]  werr[4];
    int lat; logic [SW-1:0] s; logic m; logic [SW-1:0] er;
    vec[0] = '0;  md[0] = 1'b0; want[0] = 11'd0;    werr[0] = 11'd0;
    vec[1] = '0;  md[1] = 1'b1; want[1] = 11'd1;    werr[1] = 11'd1;
    vec[2] = '1;  md[2] = 1'b0; want[2] = 11'd2040; werr[2] = 11'd0;
    vec[3] = '1;  md[3] = 1'b1; want[3] = 11'd2047; werr[3] = 11'd7;
    for (int i = 0; i < 4; i++) begin
      run_one(vec[i], md[i], lat, s, m, er);
      n_checks++; if (lat != 3) begin n_errors++; $display("FAIL corner%0d_latency: got %0d expected 3", i, lat); end
      n_checks++; if (s !== want[i]) begin n_errors++; $display("FAIL corner%0d_sum: got %0d expected %0d", i, s, want[i]); end
      n_checks++; if (m !== md[i]) begin n_errors++; $display("FAIL corner%0d_mode: got %b expected %b", i, m, md[i]); end
`ifdef ERR_MON_EN
      n_checks++; if (er !== werr[i]) begin n_errors++; $display("FAIL corner%0d_err_abs: got %0d expected %0d", i, er, werr[i]); end
`endif
      clear_model();
    end
  endtask

  task automatic test_back_to_back();
    int got, last_idx, acc;
    got = 0; last_idx = -1; acc = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) step(1'b1, rand_vec(), 1'(i % 2), 1'b1);
      else       step(1'b0, '0, 1'b0, 1'b1);
      if (did_in) acc++;
      if (did_out) begin
        if (got > 0) begin
          n_checks++; if (i != last_idx + 1) begin n_errors++; $display("FAIL b2b_gap: got step %0d expected %0d", i, last_idx + 1); end
        end
        n_checks++; if (obs_sum !== exp_sum[0]) begin n_errors++; $display("FAIL b2b_sum: got %0d expected %0d", obs_sum, exp_sum[0]); end
        n_checks++; if (obs_mode !== exp_mode[0]) begin n_errors++; $display("FAIL b2b_mode: got %b expected %b", obs_mode, exp_mode[0]); end
        void'(exp_sum.pop_front()); void'(exp_mode.pop_front()); void'(exp_err.pop_front());
        last_idx = i; got++;
      end
    end
    n_checks++; if (acc != 8) begin n_errors++; $display("FAIL b2b_accepted: got %0d expected 8", acc); end
    n_checks++; if (got != 8) begin n_errors++; $display("FAIL b2b_results: got %0d expected 8", got); end
    clear_model();
  endtask

  task automatic test_stall();
    logic [SW-1:0] held;
    int got;
    got = 0;
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'($urandom()), 1'b1);
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_vec(), 1'($urandom()), 1'b0);
      if (i == 0) held = obs_sum;
      n_checks++; if (did_in !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (obs_valid !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid: got %b expected 1", obs_valid); end
      n_checks++; if (obs_sum !== held) begin n_errors++; $display("FAIL stall_sum_stable: got %0d expected %0d", obs_sum, held); end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'(i < 4), rand_vec(), 1'($urandom()), 1'b1);
      if (did_out) begin
        got++;
        n_checks++; if (obs_sum !== exp_sum[0] || obs_mode !== exp_mode[0]) begin
          n_errors++; $display("FAIL stall_drain: got %0d/%b expected %0d/%b", obs_sum, obs_mode, exp_sum[0], exp_mode[0]);
        end
        void'(exp_sum.pop_front()); void'(exp_mode.pop_front()); void'(exp_err.pop_front());
      end
    end
    n_checks++; if (got != 7 || exp_sum.size() != 0) begin
      n_errors++; $display("FAIL stall_count: got %0d results expected 7 (left %0d)", got, exp_sum.size());
    end
    clear_model();
  endtask

  task automatic test_reset_flight();
    logic [N*W-1:0] d;
    logic m, md;
    int lat; logic [SW-1:0] s, er;
    longint want;
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstfl_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sum !== '0) begin n_errors++; $display("FAIL rstfl_sum: got %0d expected 0", out_sum); end
    rst = 1'b0;
    clear_model();
    model_max = 0;
    d = rand_vec(); m = 1'b1;
    want = ref_sum(d, m);
    run_one(d, m, lat, s, md, er);
    n_checks++; if (lat != 3) begin n_errors++; $display("FAIL rstfl_latency: got %0d expected 3", lat); end
    n_checks++; if (s !== SW'(want)) begin n_errors++; $display("FAIL rstfl_first_sum: got %0d expected %0d", s, want); end
    clear_model();
  endtask

  task automatic test_random();
    int acc, bad;
    acc = 0; bad = 0;
    for (int i = 0; i < 60000 && acc < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_vec(), 1'($urandom()), 1'($urandom_range(0, 3) != 0));
      if (did_in) acc++;
      if (did_out) begin
        n_checks++;
        if (exp_sum.size() == 0) begin
          n_errors++; $display("FAIL rand_extra: got %0d with empty model", obs_sum);
        end else begin
          if (obs_sum !== exp_sum[0] || obs_mode !== exp_mode[0]
`ifdef ERR_MON_EN
              || obs_err !== exp_err[0]
`endif
             ) begin
            n_errors++;
            if (bad < 10) $display("FAIL rand_sample: got %0d/%b/%0d expected %0d/%b/%0d",
                                   obs_sum, obs_mode, obs_err, exp_sum[0], exp_mode[0], exp_err[0]);
            bad++;
          end
          void'(exp_sum.pop_front()); void'(exp_mode.pop_front()); void'(exp_err.pop_front());
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (did_out) begin
        n_checks++;
        if (exp_sum.size() == 0 || obs_sum !== exp_sum[0] || obs_mode !== exp_mode[0]) begin
          n_errors++; $display("FAIL rand_drain: got %0d/%b", obs_sum, obs_mode);
        end
        if (exp_sum.size() > 0) begin
          void'(exp_sum.pop_front()); void'(exp_mode.pop_front()); void'(exp_err.pop_front());
        end
      end
    end
    n_checks++; if (acc != 10000) begin n_errors++; $display("FAIL rand_accepted: got %0d expected 10000", acc); end
    n_checks++; if (exp_sum.size() != 0) begin n_errors++; $display("FAIL rand_lost: got %0d pending expected 0", exp_sum.size()); end
`ifdef ERR_MON_EN
    #1;
    n_checks++; if (longint'(err_max) != model_max) begin n_errors++; $display("FAIL rand_err_max: got %0d expected %0d", err_max, model_max); end
`endif
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
